// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size and key-schedule operation encodings,
// per-mode word counts and the GF(2^8) reduction constant.
package aes_pkg;

    // Key size selector as presented by the key-load controller
    typedef enum logic [1:0] {
        KM_128  = 2'd0,
        KM_192  = 2'd1,
        KM_256  = 2'd2,
        KM_RSVD = 2'd3
    } key_mode_t;

    // Operation the key-expansion datapath applies to the previous word
    typedef enum logic [1:0] {
        OP_XOR          = 2'd0,
        OP_ROT_SUB_RCON = 2'd1,
        OP_SUB_ONLY     = 2'd2,
        OP_RSVD         = 2'd3
    } op_t;

    // Key length in 32-bit words
    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    // Index of the final expanded-key word, 4*(Nr+1)-1
    localparam logic [5:0] LAST_IDX_128 = 6'd43;
    localparam logic [5:0] LAST_IDX_192 = 6'd51;
    localparam logic [5:0] LAST_IDX_256 = 6'd59;

    // x^8 reduction for GF(2^8) doubling, and the first round constant
    localparam logic [7:0] RCON_POLY = 8'h1B;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input key_mode_t m);
        case (m)
            KM_192:  nk_of = NK_192;
            KM_256:  nk_of = NK_256;
            default: nk_of = NK_128;
        endcase
    endfunction

    function automatic logic [5:0] last_idx_of(input key_mode_t m);
        case (m)
            KM_192:  last_idx_of = LAST_IDX_192;
            KM_256:  last_idx_of = LAST_IDX_256;
            default: last_idx_of = LAST_IDX_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_rcon_seq_if.sv
// Word-descriptor stream from the key-schedule sequencer to the
// key-expansion datapath (valid/ready handshake).
interface aes_rcon_seq_if #(
    parameter int IDX_W = 6
) ();
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       op;
    logic [31:0]      rcon;
    logic             last;

    // Sequencer side: produces descriptors, observes ready
    modport master (
        output out_valid,
        output word_idx,
        output op,
        output rcon,
        output last,
        input  out_ready
    );

    // Datapath side: consumes descriptors, drives ready
    modport slave (
        input  out_valid,
        input  word_idx,
        input  op,
        input  rcon,
        input  last,
        output out_ready
    );
endinterface

// File: rtl/aes_xtime.sv
// Combinational GF(2^8) doubling (xtime) with the AES reduction polynomial.
// Shared between the round-constant generator and MixColumns.
module aes_xtime
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);

endmodule

// File: rtl/aes_rcon_seq.sv
// AES key-schedule sequencer. One start pulse walks the expanded-key word
// index from Nk to the last word, emitting per word the operation class and
// the round constant. The constant is produced by repeated GF(2^8) doubling
// and i mod Nk comes from a wrapping phase counter, so no table or divider
// is needed. All descriptor outputs are registered.
module aes_rcon_seq
    import aes_pkg::*;
#(
    parameter bit RCON_MSB = 1'b1,
    parameter int IDX_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_mode,
    output logic                  busy,
    output logic                  err,
    aes_rcon_seq_if.master        desc
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_n;
    key_mode_t        mode_q, mode_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [2:0]       phase_q, phase_n;
    logic [7:0]       rbyte_q, rbyte_n;
    logic [7:0]       rbyte_dbl;
    logic             valid_q, valid_n;
    logic             busy_q, busy_n;
    logic             last_q, last_n;
    logic             err_q, err_n;
    op_t              op_q, op_n;
    logic [31:0]      rcon_q, rcon_n;

    key_mode_t        mode_in;
    logic [3:0]       nk_cur;
    logic [IDX_W-1:0] last_cur;
    logic             phase_wrap;
    logic             handshake;

    // Operation class from the position of the word inside its Nk-word group
    function automatic op_t classify(input logic [2:0] ph, input logic [3:0] nk);
        if (ph == 3'd0)
            classify = OP_ROT_SUB_RCON;
        else if (nk == NK_256 && ph == 3'd4)
            classify = OP_SUB_ONLY;
        else
            classify = OP_XOR;
    endfunction

    // Round-constant byte positioned inside the 32-bit word
    function automatic logic [31:0] place_rcon(input logic [7:0] b);
        if (RCON_MSB)
            place_rcon = {b, 24'h000000};
        else
            place_rcon = {24'h000000, b};
    endfunction

    aes_xtime u_xtime (
        .a (rbyte_q),
        .y (rbyte_dbl)
    );

    assign mode_in    = key_mode_t'(key_mode);
    assign nk_cur     = nk_of(mode_q);
    assign last_cur   = IDX_W'(last_idx_of(mode_q));
    assign phase_wrap = (phase_q == 3'(nk_cur - 4'd1));
    assign handshake  = valid_q & desc.out_ready;

    // Next-state and next-descriptor computation for the two-state sequencer
    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        idx_n   = idx_q;
        phase_n = phase_q;
        rbyte_n = rbyte_q;
        valid_n = valid_q;
        busy_n  = busy_q;
        last_n  = last_q;
        op_n    = op_q;
        rcon_n  = rcon_q;
        err_n   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode_in == KM_RSVD) begin
                        err_n = 1'b1;
                    end else begin
                        // First word of every schedule is i = Nk, a rotate word
                        state_n = S_RUN;
                        mode_n  = mode_in;
                        idx_n   = IDX_W'(nk_of(mode_in));
                        phase_n = 3'd0;
                        rbyte_n = RCON_INIT;
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                        last_n  = 1'b0;
                        op_n    = OP_ROT_SUB_RCON;
                        rcon_n  = place_rcon(RCON_INIT);
                    end
                end
            end

            S_RUN: begin
                if (handshake) begin
                    if (last_q) begin
                        state_n = S_IDLE;
                        idx_n   = '0;
                        phase_n = 3'd0;
                        rbyte_n = RCON_INIT;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        last_n  = 1'b0;
                        op_n    = OP_XOR;
                        rcon_n  = 32'h0;
                    end else begin
                        idx_n   = idx_q + 1'b1;
                        phase_n = phase_wrap ? 3'd0 : phase_q + 3'd1;
                        // The constant is consumed only by rotate words
                        if (op_q == OP_ROT_SUB_RCON)
                            rbyte_n = rbyte_dbl;
                        op_n   = classify(phase_n, nk_cur);
                        rcon_n = (op_n == OP_ROT_SUB_RCON) ? place_rcon(rbyte_n) : 32'h0;
                        last_n = (idx_n == last_cur);
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset discards any schedule
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= KM_128;
            idx_q   <= '0;
            phase_q <= 3'd0;
            rbyte_q <= RCON_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= OP_XOR;
            rcon_q  <= 32'h0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            idx_q   <= idx_n;
            phase_q <= phase_n;
            rbyte_q <= rbyte_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            last_q  <= last_n;
            err_q   <= err_n;
            op_q    <= op_n;
            rcon_q  <= rcon_n;
        end
    end

    assign desc.out_valid = valid_q;
    assign desc.word_idx  = idx_q;
    assign desc.op        = op_q;
    assign desc.rcon      = rcon_q;
    assign desc.last      = last_q;
    assign busy           = busy_q;
    assign err            = err_q;

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Bench for aes_rcon_seq: two instances (rcon in MSB and in LSB) share
// stimulus; a word-level key-schedule model predicts every output each cycle.
module tb_aes_rcon_seq;

    localparam int IDX_W = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] key_mode = 2'd0;
    logic       ready = 1'b0;
    logic       busy1, err1, busy0, err0;

    aes_rcon_seq_if #(.IDX_W(IDX_W)) if1 ();
    aes_rcon_seq_if #(.IDX_W(IDX_W)) if0 ();

    assign if1.out_ready = ready;
    assign if0.out_ready = ready;

    aes_rcon_seq #(.RCON_MSB(1'b1), .IDX_W(IDX_W)) dut_msb (
        .clk(clk), .rst(rst), .start(start), .key_mode(key_mode),
        .busy(busy1), .err(err1), .desc(if1)
    );

    aes_rcon_seq #(.RCON_MSB(1'b0), .IDX_W(IDX_W)) dut_lsb (
        .clk(clk), .rst(rst), .start(start), .key_mode(key_mode),
        .busy(busy0), .err(err0), .desc(if0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model (word level) ----------------
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    bit exp_running = 0;
    bit exp_err = 0;
    int exp_i = 0;
    int exp_nk = 4;

    function automatic int nk_for(input int m);
        return (m == 1) ? 6 : (m == 2) ? 8 : 4;
    endfunction

    function automatic int last_for(input int nk);
        return 4 * (nk + 6 + 1) - 1;
    endfunction

    function automatic int op_for(input int i, input int nk);
        if (i % nk == 0) return 1;
        if (nk == 8 && i % nk == 4) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_running = 0;
            exp_err = 0;
        end else begin
            exp_err = 0;
            if (!exp_running) begin
                if (start) begin
                    if (key_mode == 2'd3) begin
                        exp_err = 1;
                    end else begin
                        exp_running = 1;
                        exp_nk = nk_for(int'(key_mode));
                        exp_i = exp_nk;
                    end
                end
            end else if (ready) begin
                if (exp_i == last_for(exp_nk)) exp_running = 0;
                else exp_i++;
            end
        end
    end

    // ---------------- per-cycle compare and handshake log ----------------
    bit cmp_en = 0;
    int hs_cnt, busy_cyc, last_seen, first_op2;
    logic [7:0]  rq [$];
    logic [31:0] lsbq [$];

    always @(negedge clk) begin
        if (cmp_en) begin
            int e_op;
            logic [7:0] e_byte;
            e_op = exp_running ? op_for(exp_i, exp_nk) : 0;
            e_byte = (e_op == 1) ? rcon_tab[exp_i / exp_nk - 1] : 8'h00;
            chk("valid", 32'(if1.out_valid), 32'(exp_running));
            chk("busy", 32'(busy1), 32'(exp_running));
            chk("err", 32'(err1), 32'(exp_err));
            chk("idx", 32'(if1.word_idx), exp_running ? exp_i : 0);
            chk("op", 32'(if1.op), e_op);
            chk("rcon_msb", if1.rcon, {e_byte, 24'h0});
            chk("last", 32'(if1.last), 32'(exp_running && exp_i == last_for(exp_nk)));
            chk("lsb_valid", 32'(if0.out_valid), 32'(exp_running));
            chk("lsb_busy", 32'(busy0), 32'(exp_running));
            chk("lsb_err", 32'(err0), 32'(exp_err));
            chk("lsb_idx", 32'(if0.word_idx), exp_running ? exp_i : 0);
            chk("lsb_op", 32'(if0.op), e_op);
            chk("rcon_lsb", if0.rcon, {24'h0, e_byte});
            chk("lsb_last", 32'(if0.last), 32'(exp_running && exp_i == last_for(exp_nk)));
            if (busy1) busy_cyc++;
            if (if1.out_valid && ready) begin
                hs_cnt++;
                if (if1.op == 2'd1) begin
                    rq.push_back(if1.rcon[31:24]);
                    lsbq.push_back(if0.rcon);
                end
                if (if1.op == 2'd2 && first_op2 < 0) first_op2 = int'(if1.word_idx);
                if (if1.last) last_seen = int'(if1.word_idx);
            end
        end
    end

    function automatic logic [31:0] rq_at(input int k);
        return (k < rq.size()) ? 32'(rq[k]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] lsbq_at(input int k);
        return (k < lsbq.size()) ? lsbq[k] : 32'hDEAD_BEEF;
    endfunction

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [1:0] m);
        hs_cnt = 0; busy_cyc = 0; last_seen = -1; first_op2 = -1;
        rq.delete(); lsbq.delete();
        @(posedge clk); #1;
        start = 1'b1; key_mode = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // ready_mode: 1 = always ready, 0 = random; chaos toggles start/key_mode
    task automatic run(input bit ready_mode, input bit chaos, input int rst_at, input string tag);
        int cyc = 0;
        while (exp_running) begin
            if (cyc >= 400) begin
                chk({tag, "_timeout"}, 32'(cyc), 32'd400 - 1);
                break;
            end
            if (rst_at >= 0 && exp_i == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            ready = ready_mode ? 1'b1 : 1'($urandom_range(0, 1));
            if (chaos) begin
                key_mode = 2'($urandom_range(0, 3));
                start = (exp_i == last_for(exp_nk)) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        key_mode = 2'd0;
        ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1;
        chk("rst_valid", 32'(if1.out_valid), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_idx", 32'(if1.word_idx), 0);
        chk("rst_rcon", if1.rcon, 0);
        rst = 1'b0;

        // AES-128, always ready
        do_start(2'd0);
        chk("start_idx", 32'(if1.word_idx), 4);
        chk("start_op", 32'(if1.op), 1);
        chk("start_rcon", if1.rcon, 32'h0100_0000);
        run(1'b1, 1'b0, -1, "aes128");
        chk("hs128", 32'(hs_cnt), 40);
        chk("cyc128", 32'(busy_cyc), 40);
        chk("nrot128", 32'(rq.size()), 10);
        for (int k = 0; k < 10; k++) chk("rcon128_seq", rq_at(k), 32'(rcon_tab[k]));
        chk("rcon128_9th", rq_at(8), 32'h1B);
        chk("last128", 32'(last_seen), 43);
        chk("lsb128_first", lsbq_at(0), 32'h0000_0001);
        chk("lsb128_tenth", lsbq_at(9), 32'h0000_0036);

        // AES-256, always ready
        do_start(2'd2);
        run(1'b1, 1'b0, -1, "aes256");
        chk("hs256", 32'(hs_cnt), 52);
        chk("cyc256", 32'(busy_cyc), 52);
        chk("nrot256", 32'(rq.size()), 7);
        chk("rcon256_last", rq_at(6), 32'h40);
        chk("first_op2", 32'(first_op2), 12);
        chk("last256", 32'(last_seen), 59);
        chk("busy256_end", 32'(busy1), 0);

        // AES-192 with random backpressure
        do_start(2'd1);
        run(1'b0, 1'b0, -1, "aes192");
        chk("hs192", 32'(hs_cnt), 46);
        chk("nrot192", 32'(rq.size()), 8);
        chk("rcon192_last", rq_at(7), 32'h80);
        chk("last192", 32'(last_seen), 51);

        // Reset mid-schedule at i = 20, then a clean AES-128 restart
        do_start(2'd0);
        run(1'b1, 1'b0, 20, "rst_mid");
        chk("rst_mid_busy", 32'(busy1), 0);
        do_start(2'd0);
        chk("restart_idx", 32'(if1.word_idx), 4);
        chk("restart_rcon", if1.rcon, 32'h0100_0000);
        run(1'b1, 1'b0, -1, "restart");
        chk("hs_restart", 32'(hs_cnt), 40);
        chk("rcon_restart_last", rq_at(9), 32'h36);

        // Reserved mode: single err pulse, no schedule
        do_start(2'd3);
        chk("err_pulse", 32'(err1), 1);
        chk("err_busy", 32'(busy1), 0);
        @(posedge clk); #1;
        chk("err_clear", 32'(err1), 0);

        // AES-128 with start pulses and key_mode toggling during RUN
        do_start(2'd0);
        run(1'b1, 1'b1, -1, "chaos");
        chk("hs_chaos", 32'(hs_cnt), 40);
        chk("rcon_chaos_last", rq_at(9), 32'h36);
        chk("chaos_idle", 32'(busy1), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
